// File: rtl/calc_zbuf_if.sv
// calc_zbuf handshake bundle: calc results in,
// buffered results out, throttle and occupancy.
interface calc_zbuf_if #(
  parameter int DEPTH = 16
);
  logic [31:0]              Z;
  logic                     pushZ;
  logic [31:0]              Zo;
  logic                     pushZo;
  logic                     stopZo;
  logic                     hold;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output Z, pushZ, stopZo,
    input  Zo, pushZo, hold, level
  );

  modport slave (
    input  Z, pushZ, stopZo,
    output Zo, pushZo, hold, level
  );
endinterface

// File: rtl/calc_zbuf.sv
// calc_zbuf: result FIFO behind calc with early hold.
// Optional drop tracking under CALC_ZBUF_OVF_EN.
module calc_zbuf #(
  parameter int DEPTH       = 16,
  parameter int HOLD_MARGIN = 9
) (
  input  logic         clk,
  input  logic         rst,
  calc_zbuf_if.slave   bus
`ifdef CALC_ZBUF_OVF_EN
  ,
  output logic         ovf,
  output logic [15:0]  ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C =
    CW'(DEPTH);
  localparam logic [CW-1:0] HOLD_C =
    CW'(DEPTH - HOLD_MARGIN);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          hold_q;
  logic          pop;
  logic          wr;

  // Pop needs a head; a write needs space or a pop
  // freeing a slot on the same edge.
  always_comb begin
    pop = (cnt != '0) && !bus.stopZo;
    wr  = bus.pushZ && ((cnt != FULL_C) || pop);
    unique case ({wr, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  // Pointers, occupancy and registered hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      hold_q <= 1'b0;
    end else begin
      if (wr)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      cnt    <= cnt_nxt;
      hold_q <= (cnt_nxt >= HOLD_C);
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr)
      mem[wp] <= bus.Z;
  end

  assign bus.pushZo = (cnt != '0);
  assign bus.Zo     = (cnt != '0) ? mem[rp]
                                  : 32'h0;
  assign bus.hold   = hold_q;
  assign bus.level  = cnt;

`ifdef CALC_ZBUF_OVF_EN
  logic drop;

  assign drop = bus.pushZ && !wr;

  // Sticky flag and saturating count of drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf     <= 1'b0;
      ovf_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_cnt != 16'hFFFF)
        ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_calc_zbuf.sv
// tb_calc_zbuf: directed checks for calc_zbuf.
// Drives one cycle at a time, checks 1ns after edge.
module tb_calc_zbuf;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] q[$];
  logic        m_pop;
  logic        m_wr;
  int          n;

  calc_zbuf_if #(.DEPTH(16)) bus ();

`ifdef CALC_ZBUF_OVF_EN
  logic        ovf;
  logic [15:0] ovf_cnt;
`endif

  calc_zbuf #(
    .DEPTH      (16),
    .HOLD_MARGIN(9)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus)
`ifdef CALC_ZBUF_OVF_EN
    ,
    .ovf    (ovf),
    .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    bus.Z      = '0;
    bus.pushZ  = 1'b0;
    bus.stopZo = 1'b0;
    #3;
    chk("rst_pv",  32'(bus.pushZo), 32'h0);
    chk("rst_zo",  bus.Zo,          32'h0);
    chk("rst_hld", 32'(bus.hold),   32'h0);
    chk("rst_lvl", 32'(bus.level),  32'h0);
`ifdef CALC_ZBUF_OVF_EN
    chk("rst_ovf", 32'(ovf),        32'h0);
    chk("rst_oc",  32'(ovf_cnt),    32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;
    step();

    // single write, one cycle visible
    bus.Z     = 32'h55;
    bus.pushZ = 1'b1;
    step();
    bus.pushZ = 1'b0;
    chk("one_pv",  32'(bus.pushZo), 32'h1);
    chk("one_zo",  bus.Zo,          32'h55);
    chk("one_lvl", 32'(bus.level),  32'h1);
    step();
    chk("one_pv0", 32'(bus.pushZo), 32'h0);
    chk("one_l0",  32'(bus.level),  32'h0);
    chk("one_z0",  bus.Zo,          32'h0);

    // stall and fill 1..16
    bus.stopZo = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.Z     = 32'(i);
      bus.pushZ = 1'b1;
      step();
      chk("fill_lvl", 32'(bus.level), 32'(i));
      chk("fill_hld", 32'(bus.hold),
          32'(i >= 7));
    end

    // overflow while full and stalled
    bus.Z = 32'hDEAD;
    step();
    bus.pushZ = 1'b0;
    chk("ovf_lvl", 32'(bus.level), 32'd16);
    chk("ovf_hld", 32'(bus.hold),  32'h1);
    chk("ovf_zo",  bus.Zo,         32'h1);
`ifdef CALC_ZBUF_OVF_EN
    chk("ovf_flg", 32'(ovf),       32'h1);
    chk("ovf_cnt", 32'(ovf_cnt),   32'h1);
`endif

    // drain 1..16, DEAD must not appear
    bus.stopZo = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("drn_pv", 32'(bus.pushZo), 32'h1);
      chk("drn_zo", bus.Zo, 32'(i));
      step();
      chk("drn_lvl", 32'(bus.level),
          32'(16 - i));
      chk("drn_hld", 32'(bus.hold),
          32'(16 - i >= 7));
    end
    chk("drn_pv0", 32'(bus.pushZo), 32'h0);
    chk("drn_z0",  bus.Zo,          32'h0);

    // push and pop together at full
    bus.stopZo = 1'b1;
    q.delete();
    for (int i = 1; i <= 16; i++) begin
      bus.Z     = 32'h100 + 32'(i);
      bus.pushZ = 1'b1;
      q.push_back(bus.Z);
      step();
    end
    bus.stopZo = 1'b0;
    bus.Z      = 32'h77;
    step();
    bus.pushZ = 1'b0;
    void'(q.pop_front());
    q.push_back(32'h77);
    chk("pp_lvl", 32'(bus.level), 32'd16);
    chk("pp_zo",  bus.Zo,         32'h102);
`ifdef CALC_ZBUF_OVF_EN
    chk("pp_oc",  32'(ovf_cnt),   32'h1);
`endif
    for (int i = 0; i < 16; i++) begin
      chk("pp_drn", bus.Zo, q.pop_front());
      step();
    end
    chk("pp_last", 32'(bus.level), 32'h0);

    // wrap-around with stop toggling
    for (int k = 0; k < 40; k++) begin
      bus.stopZo = ((k / 3) % 2) == 1;
      bus.pushZ  = 1'b1;
      bus.Z      = 32'h1000 + 32'(k);
      if (q.size() != 0)
        chk("wr_zo", bus.Zo, q[0]);
      m_pop = (q.size() != 0) && !bus.stopZo;
      m_wr  = (q.size() < 16) || m_pop;
      step();
      if (m_pop)
        void'(q.pop_front());
      if (m_wr)
        q.push_back(32'h1000 + 32'(k));
      chk("wr_lvl", 32'(bus.level),
          32'(q.size()));
      chk("wr_max", 32'(bus.level <= 16),
          32'h1);
    end
    bus.pushZ  = 1'b0;
    bus.stopZo = 1'b0;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      chk("wr_drn", bus.Zo, q.pop_front());
      step();
    end
    chk("wr_end", 32'(bus.level), 32'h0);

    // mid-operation async reset
    bus.stopZo = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.Z     = 32'h200 + 32'(i);
      bus.pushZ = 1'b1;
      step();
    end
    bus.pushZ = 1'b0;
    chk("mr_pre", 32'(bus.level), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_pv",  32'(bus.pushZo), 32'h0);
    chk("mr_zo",  bus.Zo,          32'h0);
    chk("mr_lvl", 32'(bus.level),  32'h0);
    #1;
    rst = 1'b1;
    step();
    bus.Z     = 32'hABC;
    bus.pushZ = 1'b1;
    step();
    bus.pushZ = 1'b0;
    chk("mr_new", bus.Zo,          32'hABC);
    chk("mr_l1",  32'(bus.level),  32'h1);
`ifdef CALC_ZBUF_OVF_EN
    chk("mr_ovf", 32'(ovf),        32'h0);
`endif
    bus.stopZo = 1'b0;
    step();
    chk("mr_l0",  32'(bus.level),  32'h0);
    chk("mr_pv0", 32'(bus.pushZo), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
